// File: rtl/comparador_serial_izq_der_if.sv
// rtl/comparador_serial_izq_der_if.sv - bit-pair stream and result bus of the serial comparator
interface comparador_serial_izq_der_if;
  logic start;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic busy;
  logic decided;
  logic done;
  logic lt;
  logic eq;
  logic gt;
  logic z;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  busy, decided, done, lt, eq, gt, z
  );

  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output busy, decided, done, lt, eq, gt, z
  );
endinterface

// File: rtl/comparador_serial_izq_der.sv
// rtl/comparador_serial_izq_der.sv - MSB-first bit-serial magnitude comparator
// The relation latches at the first unequal bit; all N bits are still consumed before done.
module comparador_serial_izq_der #(
  parameter int N = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  comparador_serial_izq_der_if.slave   bus
);
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, S_EQ, S_GT, S_LT} state_t;

  state_t        state, state_nx, rel;
  logic [CW-1:0] count, count_nx;
  logic          busy_q, decided_q, done_q, lt_q, eq_q, gt_q, z_q;
  logic          busy_nx, decided_nx, done_nx, lt_nx, eq_nx, gt_nx, z_nx;
  logic          accept, last;

  // start wins over a bit presented in the same cycle, so that bit is never accepted
  assign accept = (state != IDLE) && bus.bit_valid && !bus.start;
  assign last   = (count == LAST);

  always_comb begin
    rel = state;
    if (state == S_EQ) begin
      if (bus.a_bit && !bus.b_bit)      rel = S_GT;
      else if (!bus.a_bit && bus.b_bit) rel = S_LT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      busy_q    <= 1'b0;
      decided_q <= 1'b0;
      done_q    <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      z_q       <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      busy_q    <= busy_nx;
      decided_q <= decided_nx;
      done_q    <= done_nx;
      lt_q      <= lt_nx;
      eq_q      <= eq_nx;
      gt_q      <= gt_nx;
      z_q       <= z_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    if (bus.start) begin
      state_nx = S_EQ;
      count_nx = '0;
    end else if (accept) begin
      if (last) begin
        state_nx = IDLE;
        count_nx = '0;
      end else begin
        state_nx = rel;
        count_nx = count + CW'(1);
      end
    end
  end

  always_comb begin
    busy_nx    = (state_nx != IDLE);
    done_nx    = 1'b0;
    decided_nx = decided_q;
    lt_nx      = lt_q;
    eq_nx      = eq_q;
    gt_nx      = gt_q;
    z_nx       = z_q;
    if (bus.start) begin
      decided_nx = 1'b0;
      lt_nx      = 1'b0;
      eq_nx      = 1'b0;
      gt_nx      = 1'b0;
      z_nx       = 1'b0;
    end else if (accept) begin
      decided_nx = (rel != S_EQ);
      if (last) begin
        done_nx = 1'b1;
        lt_nx   = (rel == S_LT);
        eq_nx   = (rel == S_EQ);
        gt_nx   = (rel == S_GT);
        z_nx    = (rel != S_GT);
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.decided = decided_q;
  assign bus.done    = done_q;
  assign bus.lt      = lt_q;
  assign bus.eq      = eq_q;
  assign bus.gt      = gt_q;
  assign bus.z       = z_q;
endmodule

// File: doc/comparador_serial_izq_der.md
Name: comparador_serial_izq_der

Overview:
- Bit-serial magnitude comparator for two unsigned N-bit words.
- Scans from left to right: MSB first, one bit pair per accepted beat.
- Sequential counterpart of the right-to-left iterative comparator network. It produces the same final relation Z = (A <= B), plus lt/eq/gt flags.
- Sits between a serializer (shift-out of A and B) and the result-capture logic.
- Because scanning starts at the MSB, the relation is known at the first unequal bit. The `decided` flag exposes this early; the block still consumes all N bits before `done`.

Parameters:
- N, 8, word width in bits (N >= 1).
- CW, $clog2(N+1), bit-counter width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a new comparison; 1-cycle pulse.
- bit_valid  in  1  a_bit/b_bit carry a valid bit pair this cycle.
- a_bit  in  1  current bit of A, MSB first.
- b_bit  in  1  current bit of B, MSB first.
- busy  out  1  comparison in progress.
- decided  out  1  relation already fixed (first unequal bit seen).
- done  out  1  1-cycle pulse; result flags valid from this cycle.
- lt  out  1  A < B.
- eq  out  1  A == B.
- gt  out  1  A > B.
- z  out  1  A <= B (lt | eq).

Behaviour:
- All outputs are registered.
- Reset (sampled at clk edge, has priority over everything):
  - state = IDLE, count = 0.
  - busy, decided, done, lt, eq, gt and z all = 0.
- States:
  - IDLE: waiting for start.
  - S_EQ: all bits so far are equal.
  - S_GT: A > B fixed.
  - S_LT: A < B fixed.
- IDLE:
  - start=1 -> S_EQ, count=0, busy=1; lt/eq/gt/z/decided cleared.
  - A bit_valid in the same cycle as start is discarded. The first bit is sampled from the next cycle.
  - bit_valid without start is ignored.
- S_EQ, on bit_valid=1:
  - a_bit=1, b_bit=0 -> S_GT, decided=1.
  - a_bit=0, b_bit=1 -> S_LT, decided=1.
  - a_bit == b_bit -> stay in S_EQ.
  - count increments.
- S_GT / S_LT, on bit_valid=1: state holds, bits are ignored for the relation, count increments.
- bit_valid=0 in any compare state: no change (gaps of any length are allowed).
- Completion: bit_valid=1 with count == N-1.
  - Next edge: state=IDLE, busy=0, done=1 for exactly one cycle.
  - lt/eq/gt are set from the final state, including the effect of this last bit. Exactly one of them is 1.
  - z = lt|eq.
- Latency: done is asserted on the edge that accepts the N-th bit. It is visible in the cycle after that bit is presented.
- Result hold: lt/eq/gt/z/decided hold after done until the next start or reset.
- Result flags are 0 while busy.
- start while busy: abort and restart. state=S_EQ, count=0, decided=0, no done pulse; a bit in the same cycle is discarded.
- Reset mid-operation: immediate return to reset values; no done pulse.
- N=1: a single bit completes. done follows the first valid bit, and decided equals (a_bit != b_bit).
- The counter never exceeds N-1 and never wraps, because the block returns to IDLE on the N-th bit.

Test Plan:
- A=0x5A, B=0x5A, bit_valid continuous after start -> decided stays 0. done pulses 1 cycle after the 8th bit with eq=1, z=1, lt=0, gt=0.
- A=0x80, B=0x7F -> decided=1 the cycle after the first bit; busy stays 1 for the remaining 7 bits. done gives gt=1, z=0.
- A=0x12, B=0x13 with bit_valid=0 gaps of 0-3 cycles between bits -> decided rises only after bit 0 (LSB). done gives lt=1, z=1; gaps do not change the count.
- After 4 bits of A=0xF0/B=0x0F, pulse start with bit_valid=1 in the same cycle, then send A=0x01, B=0x01 -> no done from the first operation. The same-cycle bit is dropped, and the second result is eq=1.
- Assert reset after 3 bits -> next cycle all outputs are 0. A subsequent bit_valid without start is ignored and busy stays 0.
- N=1 instance, A=0/B=1 then A=1/B=1 -> lt=1, z=1, decided=1, then eq=1, z=1, decided=0. Each operation gives done exactly 1 cycle after its bit.
